ram_lsu_master: RTL and testbench
=================================

Name: ram_lsu_master

Overview:
- Load/store initiator that sits between the core's memory stage and the word-only data RAM.
- Accepts one byte, halfword or word access at a time.
- Sub-word loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: performs read-modify-write, since the RAM writes whole words only.
- Flags misaligned and out-of-range accesses without ever touching the RAM.

Parameters:
- RAM_NUM, 4096, number of 32-bit words in the attached RAM; word index >= RAM_NUM is out of range.
- ADDR_W, 32, byte-address width on both sides.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_i  in  1  access request from core, sampled only while ready_o=1
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  1 = zero-extend load result, 0 = sign-extend
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready_o  out  1  block idle and able to accept a request
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o: access was misaligned, illegal size or out of range
- rdata_o  out  32  load result, registered, held until the next done_o
- ram_wr_en_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM byte address, always word-aligned ([1:0]=00)
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, combinational from ram_addr_o

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, ready_o=1.
  - done_o, err_o, ram_wr_en_o = 0.
  - rdata_o, ram_addr_o, ram_wdata_o = 0.
  - Internal latches (we, size, unsigned, lane, wdata, read buffer) = 0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - ready_o=1.
  - On req_i=1 at a clk edge: latch we_i, size_i, unsigned_i, addr_i[1:0], wdata_i; set ram_addr_o={addr_i[ADDR_W-1:2],2'b00}.
  - Error check, evaluated in IDLE on the request cycle:
    - size_i=11;
    - half with addr_i[0]=1;
    - word with addr_i[1:0]!=0;
    - addr_i[ADDR_W-1:2] >= RAM_NUM.
  - Error -> RESP with err flag set. RAM is never written. rdata_o is unchanged.
  - Load -> RD. Word store -> WR. Byte/half store -> RD.
- RD:
  - ready_o=0.
  - Capture ram_rdata_i into the read buffer at the end of the cycle.
  - Load -> RESP. Store -> WR.
- WR:
  - ram_wr_en_o=1 for exactly this one cycle.
  - ram_wdata_o:
    - word store: latched wdata;
    - byte store: read buffer with byte lane addr[1:0] replaced by wdata[7:0];
    - half store: read buffer with half lane addr[1] replaced by wdata[15:0].
  - -> RESP.
- RESP:
  - done_o=1 and err_o=error flag, both for one cycle.
  - For a non-error load, rdata_o is updated on entry to RESP:
    - byte = lane byte extended;
    - half = lane half extended;
    - word = buffer.
  - Stores leave rdata_o unchanged.
  - -> IDLE. ready_o returns to 1 in the next cycle; no back-to-back acceptance in RESP.
- Latency, counted from the accept edge (cycle 0):
  - load: done_o in cycle 2;
  - word store: write in cycle 1, done_o in cycle 2;
  - sub-word store: read in cycle 1, write in cycle 2, done_o in cycle 3;
  - error: done_o in cycle 1.
- Outputs outside their active states:
  - ram_addr_o holds its last value outside active states.
  - ram_wr_en_o=0 in every state except WR.
- Inputs ignored while ready_o=0; the core holds them stable only for the request cycle.
- rst asserted mid-operation: immediate return to IDLE with all outputs at reset values. A pending RMW is abandoned. The RAM word is left either untouched (reset before WR) or fully written (reset after the WR edge), never partially written.

Decomposition:
- Shared defines header gets:
  - size codes: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10;
  - state encodings;
  - the existing ZERO_WORD and RAM_NUM.
- One combinational sub-module, lsu_lane_align:
  - inputs: size, lane, unsigned, word and store data;
  - outputs: extracted/extended load value and merged store word.
  - Lets lane logic be unit-tested separately from the FSM.

Test Plan:
- RAM[1]=0x8899AABB; load byte, signed, addr 0x6 -> done_o at cycle 2, rdata_o=0xFFFFFF99, err_o=0, ram_wr_en_o never high.
- Same word; load half, unsigned, addr 0x6 -> rdata_o=0x00008899. Load word addr 0x4 -> rdata_o=0x8899AABB.
- RAM[2]=0x11223344; store byte 0xEE to addr 0x9 -> one ram_wr_en_o pulse in cycle 2 with ram_addr_o=0x8, ram_wdata_o=0x1122EE44; done_o cycle 3.
- Store word 0xDEADBEEF to addr 0xC -> ram_wr_en_o in cycle 1, ram_wdata_o=0xDEADBEEF, done_o cycle 2. Store half 0x5566 to addr 0xE over 0 -> final word 0x55660000.
- Errors, each giving done_o=1, err_o=1 in cycle 1 with no ram_wr_en_o and rdata_o unchanged:
  - word store to addr 0x2;
  - half load to addr 0x3;
  - size 11;
  - addr RAM_NUM*4.
- Reset mid-RMW: byte store to addr 0x9, assert rst during RD -> ready_o=1 and all outputs 0 immediately; RAM[2] unchanged. Next load from addr 0x8 completes normally.

Source files
------------

// File: rtl/ram_lsu_master_pkg.sv
// Shared constants and types for the RAM load/store initiator.
package ram_lsu_master_pkg;

  localparam logic [1:0]  SIZE_B = 2'b00;
  localparam logic [1:0]  SIZE_H = 2'b01;
  localparam logic [1:0]  SIZE_W = 2'b10;

  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam int unsigned RAM_NUM_DEFAULT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/ram_lsu_master_lsu_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import ram_lsu_master_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    case (i_size)
      SIZE_B:  o_load = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_H:  o_load = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_wdata;
    case (i_size)
      SIZE_B: begin
        o_merge = i_word;
        case (i_lane)
          2'd0:    o_merge[7:0]   = i_wdata[7:0];
          2'd1:    o_merge[15:8]  = i_wdata[7:0];
          2'd2:    o_merge[23:16] = i_wdata[7:0];
          default: o_merge[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_H: begin
        o_merge = i_word;
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/ram_lsu_master.sv
// Load/store initiator in front of a word-only RAM; sub-word stores use read-modify-write.
module ram_lsu_master
  import ram_lsu_master_pkg::*;
#(
  parameter int unsigned RAM_NUM = RAM_NUM_DEFAULT,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  lsu_state_t        r_state, w_next;
  logic              r_we, r_uns, r_err;
  logic [1:0]        r_size, r_lane;
  logic [31:0]       r_wdata, r_rbuf, r_rdata;
  logic [ADDR_W-1:0] r_addr;

  logic              w_err, w_oor;
  logic [31:0]       w_word, w_load, w_merge;

  assign w_oor = (ADDR_W'(addr_i[ADDR_W-1:2]) >= ADDR_W'(RAM_NUM));
  assign w_err = (size_i == 2'b11) ||
                 (size_i == SIZE_H && addr_i[0]) ||
                 (size_i == SIZE_W && addr_i[1:0] != 2'b00) ||
                 w_oor;

  // Loads extract from the live RAM word in RD; merges use the buffered word in WR.
  assign w_word = (r_state == ST_WR) ? r_rbuf : ram_rdata_i;

  lsu_lane_align u_align (
    .i_size     (r_size),
    .i_lane     (r_lane),
    .i_unsigned (r_uns),
    .i_word     (w_word),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_comb begin
    w_next      = r_state;
    ready_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    ram_wr_en_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          if (w_err)                 w_next = ST_RESP;
          else if (!we_i)            w_next = ST_RD;
          else if (size_i == SIZE_W) w_next = ST_WR;
          else                       w_next = ST_RD;
        end
      end
      ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
      ST_WR: begin
        ram_wr_en_o = 1'b1;
        w_next      = ST_RESP;
      end
      default: begin
        done_o = 1'b1;
        err_o  = r_err;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
      r_wdata <= ZERO_WORD;
      r_rbuf  <= ZERO_WORD;
      r_rdata <= ZERO_WORD;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (req_i) begin
          r_we    <= we_i;
          r_size  <= size_i;
          r_uns   <= unsigned_i;
          r_lane  <= addr_i[1:0];
          r_wdata <= wdata_i;
          r_err   <= w_err;
          r_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
        end
        ST_RD: begin
          r_rbuf <= ram_rdata_i;
          if (!r_we) r_rdata <= w_load;
        end
        default: ;
      endcase
    end
  end

  assign rdata_o     = r_rdata;
  assign ram_addr_o  = r_addr;
  assign ram_wdata_o = (r_state == ST_WR) ? w_merge : ZERO_WORD;

endmodule

// File: tb/tb_ram_lsu_master.sv
// Scoreboard bench for ram_lsu_master: directed accesses against a behavioural word RAM.
module tb_ram_lsu_master;

  localparam int RAM_NUM = 4096;
  localparam int ADDR_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
  logic [1:0]        size_i = 2'b00;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [31:0]       wdata_i = '0;
  logic              ready_o, done_o, err_o, ram_wr_en_o;
  logic [31:0]       rdata_o, ram_wdata_o, ram_rdata_i;
  logic [ADDR_W-1:0] ram_addr_o;

  ram_lsu_master #(.RAM_NUM(RAM_NUM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a backdoor preload port.
  logic [31:0] mem [0:RAM_NUM-1];
  logic        bd_en = 1'b0;
  logic [11:0] bd_idx = '0;
  logic [31:0] bd_val = '0;
  assign ram_rdata_i = mem[ram_addr_o[13:2]];
  always @(posedge clk) begin
    if (bd_en)            mem[bd_idx] <= bd_val;
    else if (ram_wr_en_o) mem[ram_addr_o[13:2]] <= ram_wdata_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes or writes.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          rsp_t e;
          e = rq.pop_front();
          chk("done_err", {31'd0, err_o}, {31'd0, e.err});
          chk("done_rdata", rdata_o, e.rdata);
          chk("done_cycle", cyc, e.cyc);
        end
      end
      if (ram_wr_en_o) begin
        if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", ram_addr_o, w.addr);
          chk("wr_data", ram_wdata_o, w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_idx = idx[11:0]; bd_val = val; bd_en = 1'b1;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 50) begin @(negedge clk); n++; end
    if (!ready_o) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one access; exp_rdata is rdata_o expected at done, wr_cyc 0 means no write.
  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rdata, input int done_lat,
                        input int wr_lat, input logic [31:0] e_waddr, input logic [31:0] e_wdata);
    rsp_t r;
    wr_t  w;
    wait_ready();
    we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd; req_i = 1'b1;
    r.err = e_err; r.rdata = e_rdata; r.cyc = cyc + done_lat;
    rq.push_back(r);
    if (wr_lat != 0) begin
      w.addr = e_waddr; w.data = e_wdata; w.cyc = cyc + wr_lat;
      wq.push_back(w);
    end
    @(posedge clk); #1 req_i = 1'b0;
    for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    if (rq.size() != 0 || wq.size() != 0) begin
      chk("completion_timeout", 32'd0, 32'd1);
      rq.delete(); wq.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    chk({tag, "_done"},  {31'd0, done_o}, 32'd0);
    chk({tag, "_err"},   {31'd0, err_o}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, ram_wr_en_o}, 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'h0);
    chk({tag, "_addr"},  ram_addr_o, 32'h0);
    chk({tag, "_wdata"}, ram_wdata_o, 32'h0);
  endtask

  initial begin
    poke(1, 32'h8899AABB);
    poke(2, 32'h11223344);
    poke(3, 32'h00000000);
    poke(RAM_NUM-1, 32'hCAFEF00D);
    #1 chk_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Loads from RAM[1]
    access(0, 2'b00, 0, 32'h6, 0, 0, 32'hFFFFFF99, 2, 0, 0, 0);
    access(0, 2'b01, 1, 32'h6, 0, 0, 32'h00008899, 2, 0, 0, 0);
    access(0, 2'b10, 0, 32'h4, 0, 0, 32'h8899AABB, 2, 0, 0, 0);
    access(0, 2'b00, 1, 32'h5, 0, 0, 32'h000000AA, 2, 0, 0, 0);
    access(0, 2'b01, 0, 32'h4, 0, 0, 32'hFFFFAABB, 2, 0, 0, 0);
    // Stores: byte RMW, half RMW over zero, word
    access(1, 2'b00, 0, 32'h9, 32'h000000EE, 0, 32'hFFFFAABB, 3, 2, 32'h8, 32'h1122EE44);
    access(1, 2'b01, 0, 32'hE, 32'h00005566, 0, 32'hFFFFAABB, 3, 2, 32'hC, 32'h55660000);
    access(0, 2'b10, 0, 32'hC, 0, 0, 32'h55660000, 2, 0, 0, 0);
    access(1, 2'b10, 0, 32'hC, 32'hDEADBEEF, 0, 32'h55660000, 2, 1, 32'hC, 32'hDEADBEEF);
    access(0, 2'b10, 0, 32'hC, 0, 0, 32'hDEADBEEF, 2, 0, 0, 0);
    access(0, 2'b10, 0, 32'h8, 0, 0, 32'h1122EE44, 2, 0, 0, 0);
    // Highest in-range word
    access(0, 2'b10, 0, (RAM_NUM-1)*4, 0, 0, 32'hCAFEF00D, 2, 0, 0, 0);
    // Errors: rdata_o keeps its last value, no RAM write
    access(1, 2'b10, 0, 32'h2, 32'h12345678, 1, 32'hCAFEF00D, 1, 0, 0, 0);
    access(0, 2'b01, 0, 32'h3, 0, 1, 32'hCAFEF00D, 1, 0, 0, 0);
    access(0, 2'b11, 0, 32'h0, 0, 1, 32'hCAFEF00D, 1, 0, 0, 0);
    access(0, 2'b10, 0, RAM_NUM*4, 0, 1, 32'hCAFEF00D, 1, 0, 0, 0);
    access(1, 2'b00, 0, RAM_NUM*4 + 1, 32'hFF, 1, 32'hCAFEF00D, 1, 0, 0, 0);

    // Reset during the read phase of a byte RMW
    poke(2, 32'h11223344);
    wait_ready();
    we_i = 1; size_i = 2'b00; unsigned_i = 0; addr_i = 32'h9; wdata_i = 32'hEE; req_i = 1'b1;
    @(posedge clk); #1 req_i = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1 chk_idle_outputs("midrst");
    @(negedge clk) rst = 1'b0;
    chk("midrst_ram2", mem[2], 32'h11223344);
    access(0, 2'b10, 0, 32'h8, 0, 0, 32'h11223344, 2, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("midrst_ram2_final", mem[2], 32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
